// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC,
// FSM state encoding and the fetch-buffer entry payload.
package if_stage_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Small FIFO of fetched {pc, inst} entries between memory and decode.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push         write push_entry at the tail
//   push_entry   entry to write
//   pop          drop the head entry
//   flush        empty the FIFO (wins over push/pop)
//   full, empty  occupancy flags
//   head         oldest entry (stale when empty)
module if_fetch_buf
  import if_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign head  = r_mem[r_rd_ptr];

  // A push into a full FIFO is allowed only when the head leaves at the same edge.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one memory request at a time, buffers
// responses and presents the oldest fetched instruction downstream.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   br, br_target       redirect (flushes the stage) and its target address
//   stall               stall[0]=1 holds the presented instruction
//   im_req, im_addr     instruction-memory request strobe and address
//   im_rvalid, im_rdata memory response
//   if_pc, if_inst      presented instruction and its PC
//   if_valid            presented instruction is real
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = if_stage_pkg::RESET_PC,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [1:0]        stall,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_rvalid,
  input  logic [INST_W-1:0] im_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] w_fpc_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] w_req_addr_nxt;

  logic         w_push;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  logic         w_unused_stall;

  assign w_unused_stall = stall[1];

  // State, fetch PC and address of the outstanding request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_fpc      <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fpc      <= w_fpc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // Next state, request strobe and response capture
  always_comb begin
    w_state_nxt    = r_state;
    w_fpc_nxt      = r_fpc;
    w_req_addr_nxt = r_req_addr;
    im_req         = 1'b0;
    im_addr        = '0;
    w_push         = 1'b0;

    case (r_state)
      ST_IDLE: w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (!br && !w_full) begin
          im_req         = 1'b1;
          im_addr        = r_fpc;
          w_req_addr_nxt = r_fpc;
          w_fpc_nxt      = r_fpc + ADDR_W'(4);
          w_state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A redirect with the response already here needs no KILL cycle.
        if (br) begin
          w_state_nxt = im_rvalid ? ST_REQ : ST_KILL;
        end else if (im_rvalid) begin
          w_push      = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_KILL: begin
        if (im_rvalid) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (br) begin
      w_fpc_nxt = br_target;
    end
  end

  assign w_pop        = !w_empty && !stall[0] && !br;
  assign w_push_entry = '{pc: r_req_addr, inst: im_rdata};

  if_fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_entry(w_push_entry),
    .pop       (w_pop),
    .flush     (br),
    .full      (w_full),
    .empty     (w_empty),
    .head      (w_head)
  );

  assign if_valid = !w_empty;
  assign if_pc    = w_empty ? '0 : w_head.pc;
  assign if_inst  = w_empty ? '0 : w_head.inst;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-programmable memory model
// returning inst = ~addr.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        br;
  logic [31:0] br_target;
  logic [1:0]  stall;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_pass  = 0;
  int n_total = 0;

  // memory model state
  logic        req_s  = 1'b0;
  logic [31:0] addr_s = '0;
  logic [31:0] paddr  = '0;
  bit          pend   = 1'b0;
  int          cnt    = 0;
  int          lat    = 1;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .br       (br),
    .br_target(br_target),
    .stall    (stall),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_rvalid(im_rvalid),
    .im_rdata (im_rdata),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_valid (if_valid)
  );

  always #5 clk = ~clk;

  // Requests are sampled mid-cycle, after all inputs have settled.
  always @(negedge clk) begin
    req_s  = im_req;
    addr_s = im_addr;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  // Advance one clock; memory model responds lat cycles after acceptance.
  task automatic cyc();
    @(posedge clk);
    #1;
    im_rvalid = 1'b0;
    if (req_s) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = addr_s;
    end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        im_rvalid = 1'b1;
        im_rdata  = ~paddr;
        pend      = 1'b0;
      end
    end
  endtask

  // Leaves the bench in cycle C0 with reset just released (FSM in IDLE).
  task automatic reset_dut();
    rst   = 1'b0;
    br    = 1'b0;
    stall = 2'b00;
    cyc();
    cyc();
    pend      = 1'b0;
    im_rvalid = 1'b0;
    rst       = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; br = 1'b0; br_target = '0; stall = 2'b00;
    im_rvalid = 1'b0; im_rdata = '0;
    #2;
    check("rst_req",   32'(im_req),   32'd0);
    check("rst_addr",  im_addr,       32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc",    if_pc,         32'd0);
    check("rst_inst",  if_inst,       32'd0);

    // A: 1-cycle memory, no stall (stall[1] ignored)
    lat = 1; reset_dut(); stall = 2'b10;
    #1 check("a_c0_req", 32'(im_req), 32'd0);
    cyc(); #1;
    check("a_c1_req", 32'(im_req), 32'd1);
    check("a_c1_addr", im_addr, 32'h0);
    cyc(); #1;
    check("a_c2_valid", 32'(if_valid), 32'd0);
    cyc(); #1;
    check("a_c3_valid", 32'(if_valid), 32'd1);
    check("a_c3_pc", if_pc, 32'h0);
    check("a_c3_inst", if_inst, 32'hFFFF_FFFF);
    check("a_c3_addr", im_addr, 32'h4);
    cyc(); #1;
    check("a_c4_valid", 32'(if_valid), 32'd0);
    cyc(); #1;
    check("a_c5_pc", if_pc, 32'h4);
    check("a_c5_addr", im_addr, 32'h8);
    cyc(); cyc(); #1;
    check("a_c7_valid", 32'(if_valid), 32'd1);
    check("a_c7_pc", if_pc, 32'h8);
    check("a_c7_inst", if_inst, 32'hFFFF_FFF7);

    // B: stall[0] held, FIFO fills to 2, then drains in order
    lat = 1; reset_dut(); stall = 2'b01;
    cyc(); #1 check("b_c1_addr", im_addr, 32'h0);
    cyc(); cyc(); #1;
    check("b_c3_addr", im_addr, 32'h4);
    check("b_c3_req", 32'(im_req), 32'd1);
    cyc(); cyc(); #1;
    check("b_c5_req_full", 32'(im_req), 32'd0);
    check("b_c5_pc", if_pc, 32'h0);
    cyc(); #1 check("b_c6_req_full", 32'(im_req), 32'd0);
    cyc(); #1 check("b_c7_req_full", 32'(im_req), 32'd0);
    cyc(); stall = 2'b00; #1;
    check("b_c8_pc", if_pc, 32'h0);
    check("b_c8_req", 32'(im_req), 32'd0);
    cyc(); #1;
    check("b_c9_pc", if_pc, 32'h4);
    check("b_c9_inst", if_inst, 32'hFFFF_FFFB);
    check("b_c9_addr", im_addr, 32'h8);
    cyc(); #1 check("b_c10_valid", 32'(if_valid), 32'd0);
    cyc(); #1;
    check("b_c11_pc", if_pc, 32'h8);
    check("b_c11_addr", im_addr, 32'hC);

    // C: redirect while waiting on a 3-cycle memory with one entry buffered
    lat = 3; reset_dut(); stall = 2'b01;
    cyc(); #1 check("c_c1_addr", im_addr, 32'h0);
    cyc(); cyc(); cyc(); cyc(); #1;
    check("c_c5_pc", if_pc, 32'h0);
    check("c_c5_addr", im_addr, 32'h4);
    cyc(); br = 1'b1; br_target = 32'h100; #1;
    check("c_c6_req_br", 32'(im_req), 32'd0);
    cyc(); br = 1'b0; stall = 2'b00; #1;
    check("c_c7_flushed", 32'(if_valid), 32'd0);
    cyc(); #1 check("c_c8_kill_req", 32'(im_req), 32'd0);
    cyc(); #1;
    check("c_c9_req", 32'(im_req), 32'd1);
    check("c_c9_addr", im_addr, 32'h100);
    check("c_c9_valid", 32'(if_valid), 32'd0);
    cyc(); cyc(); cyc(); cyc(); #1;
    check("c_c13_valid", 32'(if_valid), 32'd1);
    check("c_c13_pc", if_pc, 32'h100);
    check("c_c13_inst", if_inst, 32'hFFFF_FEFF);

    // D: redirect coincident with a response and a would-be push+pop
    lat = 1; reset_dut(); stall = 2'b01;
    cyc(); cyc(); cyc(); cyc();
    stall = 2'b00; br = 1'b1; br_target = 32'h200; #1;
    check("d_c4_valid", 32'(if_valid), 32'd1);
    check("d_c4_req_br", 32'(im_req), 32'd0);
    cyc(); br = 1'b0; #1;
    check("d_c5_valid", 32'(if_valid), 32'd0);
    check("d_c5_addr", im_addr, 32'h200);
    cyc(); #1 check("d_c6_valid", 32'(if_valid), 32'd0);
    cyc(); #1;
    check("d_c7_pc", if_pc, 32'h200);
    check("d_c7_inst", if_inst, 32'hFFFF_FDFF);

    // E: redirect in REQ suppresses the request; fetch PC wraps past 2^32
    lat = 1; reset_dut();
    cyc(); br = 1'b1; br_target = 32'hFFFF_FFFC; #1;
    check("e_c1_req_br", 32'(im_req), 32'd0);
    cyc(); br = 1'b0; #1;
    check("e_c2_addr", im_addr, 32'hFFFF_FFFC);
    cyc(); cyc(); #1;
    check("e_c4_pc", if_pc, 32'hFFFF_FFFC);
    check("e_c4_inst", if_inst, 32'h0000_0003);
    check("e_c4_req", 32'(im_req), 32'd1);
    check("e_c4_addr_wrap", im_addr, 32'h0);

    // F: reset asserted mid-WAIT, stale response lands while in IDLE
    lat = 1; reset_dut(); stall = 2'b01;
    cyc(); cyc(); cyc(); lat = 3;
    cyc(); #1 check("f_c4_valid", 32'(if_valid), 32'd1);
    rst = 1'b0; #1;
    check("f_rst_valid", 32'(if_valid), 32'd0);
    check("f_rst_pc", if_pc, 32'h0);
    check("f_rst_inst", if_inst, 32'h0);
    check("f_rst_req", 32'(im_req), 32'd0);
    check("f_rst_addr", im_addr, 32'h0);
    cyc(); cyc(); rst = 1'b1; stall = 2'b00; #1;
    check("f_c6_idle_req", 32'(im_req), 32'd0);
    cyc(); #1;
    check("f_c7_req", 32'(im_req), 32'd1);
    check("f_c7_addr", im_addr, 32'h0);
    check("f_c7_valid", 32'(if_valid), 32'd0);
    cyc(); #1 check("f_c8_valid", 32'(if_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2: fetched-instruction buffer entries; 2 is the only supported value.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 br  input  1  redirect from the branch unit; flushes the stage.
REQ-006 br_target  input  32  redirect address, sampled when br=1.
REQ-007 stall  input  2  pipeline stall vector; stall[0]=1 means downstream must not consume; stall[1] is ignored.
REQ-008 im_req  output  1  instruction-memory request strobe; accepted in the cycle it is high.
REQ-009 im_addr  output  32  request address, valid while im_req=1.
REQ-010 im_rvalid  input  1  read data valid; arrives at least 1 cycle after request.
REQ-011 im_rdata  input  32  instruction word, valid while im_rvalid=1.
REQ-012 if_pc  output  32  PC of the instruction presented downstream.
REQ-013 if_inst  output  32  instruction presented downstream.
REQ-014 if_valid  output  1  if_pc/if_inst hold a real instruction.

Function
REQ-015 The block SHALL hold a fetch PC register (fpc), a 4-state FSM (IDLE, REQ, WAIT, KILL) and a BUF_DEPTH-entry FIFO of {pc, inst}.
REQ-016 The block SHALL have at most one outstanding memory request at any time.
REQ-017 In REQ, im_req SHALL be 1 with im_addr=fpc only if FIFO occupancy is below BUF_DEPTH; otherwise im_req=0 and the FSM stays in REQ.
REQ-018 An issued request SHALL move the FSM REQ->WAIT and set fpc <= fpc + 4, wrapping modulo 2^32.
REQ-019 In WAIT, im_rvalid=1 SHALL push {im_addr of that request, im_rdata} into the FIFO and move the FSM to REQ.
REQ-020 if_pc/if_inst/if_valid SHALL be driven combinationally from the FIFO head; when the FIFO is empty: if_valid=0, if_pc=0, if_inst=0.
REQ-021 The head SHALL be popped at a clock edge where if_valid=1, stall[0]=0 and br=0.
REQ-022 Push and pop in the same cycle SHALL leave occupancy unchanged, and the pushed entry SHALL be ordered after the remaining entries.
REQ-023 br=1 SHALL: empty the FIFO, set fpc <= br_target, and move REQ->REQ, WAIT->KILL (KILL->KILL; IDLE unaffected), all at the same edge.
REQ-024 A response arriving in the same cycle as br=1 SHALL be discarded, and the FSM SHALL go to REQ.
REQ-025 In KILL, the next im_rvalid SHALL be discarded without a push and the FSM SHALL move to REQ; br in KILL SHALL update fpc only.
REQ-026 im_req SHALL be 0 in any cycle where br=1.
REQ-027 br SHALL take priority over stall[0].
REQ-028 The minimum latency from im_rvalid to if_valid=1 SHALL be 1 cycle.
REQ-029 Steady-state throughput SHALL be one instruction per (memory latency + 1) cycles.

Reset
REQ-030 While rst=0, the block SHALL force: FSM=IDLE, fpc=RESET_PC, FIFO empty, im_req=0, im_addr=0, if_valid=0, if_pc=0, if_inst=0.
REQ-031 Reset assertion SHALL take effect immediately, without waiting for a clk edge.
REQ-032 After rst deasserts, the FSM SHALL go IDLE->REQ at the first clk edge; the first request SHALL appear in the following cycle.
REQ-033 A response for a request in flight when reset asserted SHALL be ignored, because the FSM is in IDLE.
REQ-034 im_rvalid in IDLE SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold RESET_PC, the instruction width, the address width and the FSM state encodings.
REQ-036 The FIFO SHALL be a sub-module if_fetch_buf with push, pop, flush, full, empty and head ports, and the same asynchronous active-low reset.
REQ-037 The FSM and fpc SHALL reside in if_stage.

Verification
REQ-038 Reset release, 1-cycle memory, stall=0 -> im_addr sequence 0,4,8; if_pc 0,4,8, with if_valid=1 every second cycle.
REQ-039 stall[0]=1 held for 6 cycles, 1-cycle memory -> at most 2 entries buffered; im_req=0 when full; no loss or duplication, in order, after release.
REQ-040 br=1 with br_target=32'h100 while in WAIT (3-cycle memory) -> the pending response is dropped; the next im_addr is 32'h100; the FIFO empties; the first if_pc after is 32'h100.
REQ-041 br=1 coincident with im_rvalid and with a push plus pop -> no push; fpc=br_target; if_valid=0 in the next cycle.
REQ-042 fpc=32'hFFFF_FFFC fetched -> next im_addr is 32'h0000_0000.
REQ-043 rst asserted mid-WAIT, then im_rvalid pulsed -> outputs clear immediately; the response is ignored; after release the first im_addr is RESET_PC.
